star_spawner: RTL

- Parametrised successor to the single-shot corner spawner. Periodically emits a star spawn command: spawn point, position, signed motion, target object slot.
- Contains its own free-running Galois LFSR, a frame-tick cooldown timer, a no-immediate-repeat rule and a speed-level scaler.
- Sits between the game-state controller and the star object pool. Commands are offered with a valid/ack handshake, and a command issues only when a pool slot is free.

---
 rtl/star_spawner.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/star_spawner.sv
// star_spawner: periodic star spawn command generator. A free-running Galois LFSR
// picks a spawn point, a frame-tick cooldown paces commands, and valid/ack hands them to the pool.
module star_spawner #(
    parameter int          X_MAX        = 599,
    parameter int          Y_MAX        = 441,
    parameter int          N_SLOTS      = 4,
    parameter int          SPAWN_PERIOD = 60,
    parameter int          MODE         = 1,
    parameter int          BASE_VX      = 3,
    parameter int          BASE_VY      = 2,
    parameter logic [15:0] SEED         = 16'hACE1
) (
    input  logic                                               Clk,
    input  logic                                               Reset_n,
    input  logic                                               en,
    input  logic                                               frame_tick,
    input  logic [1:0]                                         level,
    input  logic [N_SLOTS-1:0]                                 slot_free,
    input  logic                                               spawn_ack,
    output logic                                               spawn_valid,
    output logic [((N_SLOTS > 1) ? $clog2(N_SLOTS) : 1)-1:0]   spawn_slot,
    output logic [2:0]                                         spawn_point,
    output logic signed [10:0]                                 X_Pos,
    output logic signed [10:0]                                 Y_Pos,
    output logic signed [10:0]                                 X_Motion,
    output logic signed [10:0]                                 Y_Motion
);

    localparam int SLOT_W = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
    localparam int CNT_W  = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD + 1) : 1;

    localparam logic [15:0]      SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]      LFSR_MASK  = 16'hB400;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPAWN_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
    localparam logic [2:0]       PT_MAX     = (MODE != 0) ? 3'd7 : 3'd3;
    localparam logic [10:0]      X_FULL     = 11'(X_MAX);
    localparam logic [10:0]      Y_FULL     = 11'(Y_MAX);
    localparam logic [10:0]      X_HALF     = 11'(X_MAX / 2);
    localparam logic [10:0]      Y_HALF     = 11'(Y_MAX / 2);

    typedef enum logic [1:0] {
        ST_COOLDOWN = 2'd0,
        ST_PICK     = 2'd1,
        ST_OFFER    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                has_last_q, has_last_d;
    logic [2:0]          last_q, last_d;
    logic                valid_q, valid_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [2:0]          point_q, point_d;
    logic [10:0]         x_pos_q, x_pos_d;
    logic [10:0]         y_pos_q, y_pos_d;
    logic [10:0]         x_mot_q, x_mot_d;
    logic [10:0]         y_mot_q, y_mot_d;

    logic [2:0]          raw_s;
    logic [2:0]          point_s;
    logic [SLOT_W-1:0]   slot_s;
    logic [10:0]         vx_s, vy_s;
    logic [10:0]         ent_x_s, ent_y_s, ent_mx_s, ent_my_s;

    // Candidate pick: point (with no-repeat bump), table entry and lowest free slot
    always_comb begin
        raw_s   = (MODE != 0) ? lfsr_q[2:0] : {1'b0, lfsr_q[1:0]};
        point_s = raw_s;
        if (has_last_q && (raw_s == last_q)) begin
            point_s = (raw_s == PT_MAX) ? 3'd0 : raw_s + 3'd1;
        end else begin
            point_s = raw_s;
        end

        vx_s = 11'(BASE_VX) + {9'd0, level};
        vy_s = 11'(BASE_VY) + {9'd0, level};

        case (point_s)
            3'd0:    begin ent_x_s = 11'd0;  ent_y_s = 11'd0;  ent_mx_s = vx_s;          ent_my_s = vy_s;          end
            3'd1:    begin ent_x_s = X_FULL; ent_y_s = 11'd0;  ent_mx_s = 11'd0 - vx_s;  ent_my_s = vy_s;          end
            3'd2:    begin ent_x_s = 11'd0;  ent_y_s = Y_FULL; ent_mx_s = vx_s;          ent_my_s = 11'd0 - vy_s;  end
            3'd3:    begin ent_x_s = X_FULL; ent_y_s = Y_FULL; ent_mx_s = 11'd0 - vx_s;  ent_my_s = 11'd0 - vy_s;  end
            3'd4:    begin ent_x_s = X_HALF; ent_y_s = 11'd0;  ent_mx_s = 11'd0;         ent_my_s = vy_s;          end
            3'd5:    begin ent_x_s = X_HALF; ent_y_s = Y_FULL; ent_mx_s = 11'd0;         ent_my_s = 11'd0 - vy_s;  end
            3'd6:    begin ent_x_s = 11'd0;  ent_y_s = Y_HALF; ent_mx_s = vx_s;          ent_my_s = 11'd0;         end
            3'd7:    begin ent_x_s = X_FULL; ent_y_s = Y_HALF; ent_mx_s = 11'd0 - vx_s;  ent_my_s = 11'd0;         end
            default: begin ent_x_s = 11'd0;  ent_y_s = 11'd0;  ent_mx_s = 11'd0;         ent_my_s = 11'd0;         end
        endcase

        // Descending scan so the lowest set bit wins
        slot_s = '0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (slot_free[i]) begin
                slot_s = SLOT_W'(i);
            end else begin
                slot_s = slot_s;
            end
        end
    end

    // Next-state logic: LFSR step, cooldown countdown, pick and handshake
    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        count_d    = count_q;
        has_last_d = has_last_q;
        last_d     = last_q;
        valid_d    = valid_q;
        slot_d     = slot_q;
        point_d    = point_q;
        x_pos_d    = x_pos_q;
        y_pos_d    = y_pos_q;
        x_mot_d    = x_mot_q;
        y_mot_d    = y_mot_q;

        if (en) begin
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);
            case (state_q)
                ST_COOLDOWN: begin
                    if (frame_tick) begin
                        if (count_q == CNT_ONE) begin
                            count_d = CNT_ZERO;
                            state_d = ST_PICK;
                        end else begin
                            count_d = count_q - CNT_ONE;
                        end
                    end else begin
                        count_d = count_q;
                    end
                end
                ST_PICK: begin
                    if (slot_free != '0) begin
                        valid_d    = 1'b1;
                        slot_d     = slot_s;
                        point_d    = point_s;
                        x_pos_d    = ent_x_s;
                        y_pos_d    = ent_y_s;
                        x_mot_d    = ent_mx_s;
                        y_mot_d    = ent_my_s;
                        last_d     = point_s;
                        has_last_d = 1'b1;
                        state_d    = ST_OFFER;
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                ST_OFFER: begin
                    if (spawn_ack) begin
                        valid_d = 1'b0;
                        count_d = CNT_RELOAD;
                        state_d = ST_COOLDOWN;
                    end else begin
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    valid_d = 1'b0;
                    count_d = CNT_RELOAD;
                    state_d = ST_COOLDOWN;
                end
            endcase
        end else begin
            lfsr_d = lfsr_q;
        end
    end

    // State and output registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_COOLDOWN;
            lfsr_q     <= SEED_EFF;
            count_q    <= CNT_RELOAD;
            has_last_q <= 1'b0;
            last_q     <= 3'd0;
            valid_q    <= 1'b0;
            slot_q     <= '0;
            point_q    <= 3'd0;
            x_pos_q    <= 11'd0;
            y_pos_q    <= 11'd0;
            x_mot_q    <= 11'd0;
            y_mot_q    <= 11'd0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            count_q    <= count_d;
            has_last_q <= has_last_d;
            last_q     <= last_d;
            valid_q    <= valid_d;
            slot_q     <= slot_d;
            point_q    <= point_d;
            x_pos_q    <= x_pos_d;
            y_pos_q    <= y_pos_d;
            x_mot_q    <= x_mot_d;
            y_mot_q    <= y_mot_d;
        end
    end

    assign spawn_valid = valid_q;
    assign spawn_slot  = slot_q;
    assign spawn_point = point_q;
    assign X_Pos       = x_pos_q;
    assign Y_Pos       = y_pos_q;
    assign X_Motion    = x_mot_q;
    assign Y_Motion    = y_mot_q;

endmodule
